// File: rtl/hdr_pkg.sv
// Shared types and field packing for the header stream combiner:
// FSM encoding, datamover command layout and completion layout.
package hdr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_ACK    = 3'd4
   } state_e;

   localparam int ADDR_W = 13;
   localparam int BASE_W = 19;
   localparam int BTT_W  = 23;
   localparam int CMD_W  = 72;
   localparam int CMPL_W = 24;
   localparam int TAG_W  = ADDR_W + 1;

   function automatic logic [CMD_W-1:0] make_cmd(input logic [ADDR_W-1:0] addr,
                                                 input logic [BASE_W-1:0] base,
                                                 input logic [BTT_W-1:0]  btt);
      return {4'b0, addr[3:0], addr, base, 1'b0, 1'b1, 6'b0, 1'b1, btt};
   endfunction

   // Status bit 7 is the datamover OK flag; the completion carries its inverse.
   function automatic logic [CMPL_W-1:0] make_cmpl(input logic [ADDR_W-1:0] addr,
                                                  input logic              len_err,
                                                  input logic [3:0]        stat_hi);
      return {3'b0, addr, 3'b0, len_err, ~stat_hi[3], stat_hi[2:0]};
   endfunction

endpackage

// File: rtl/hdr_tag_fifo.sv
// First-word-fall-through tag FIFO holding {len_err, addr} per outstanding command.
// set_err_i flags the MSB of the most recently pushed entry while its event streams.
module hdr_tag_fifo
   import hdr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   input  logic             set_err_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign dout_o  = mem_q[rd_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      if (push_ok) begin
         wr_d   = ptr_inc(wr_q);
         last_d = wr_q;
      end
      if (pop_ok) rd_d = ptr_inc(rd_q);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         last_q <= '0;
         cnt_q  <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din_i;
      if (set_err_i) mem_q[last_q][WIDTH-1] <= 1'b1;
   end

endmodule

// File: rtl/hdr_stream_combiner.sv
// Concatenates the TURF and TURFIO header streams into one fixed-length record per event,
// issues the matching datamover write command and turns datamover status into completions.
module hdr_stream_combiner
   import hdr_pkg::*;
#(
   parameter int               NCHAN      = 5,
   parameter int               DATA_WIDTH = 64,
   parameter logic [8*NCHAN-1:0] CHAN_BEATS = {8'd4, 8'd4, 8'd4, 8'd4, 8'd16},
   parameter logic [18:0]      BASE_ADDR  = 19'h03F00,
   parameter int               TAG_DEPTH  = 4
) (
   input  logic                        memclk,
   input  logic                        memrst,
   input  logic [NCHAN-1:0]            mask_i,
   input  logic [15:0]                 s_done_tdata,
   input  logic                        s_done_tvalid,
   output logic                        s_done_tready,
   input  logic [NCHAN*DATA_WIDTH-1:0] s_ch_tdata,
   input  logic [NCHAN-1:0]            s_ch_tvalid,
   output logic [NCHAN-1:0]            s_ch_tready,
   input  logic [NCHAN-1:0]            s_ch_tlast,
   output logic [DATA_WIDTH-1:0]       m_hdr_tdata,
   output logic                        m_hdr_tvalid,
   input  logic                        m_hdr_tready,
   output logic                        m_hdr_tlast,
   output logic [71:0]                 m_cmd_tdata,
   output logic                        m_cmd_tvalid,
   input  logic                        m_cmd_tready,
   input  logic [7:0]                  s_stat_tdata,
   input  logic                        s_stat_tvalid,
   output logic                        s_stat_tready,
   output logic [23:0]                 m_cmpl_tdata,
   output logic                        m_cmpl_tvalid,
   input  logic                        m_cmpl_tready,
   output logic [NCHAN-1:0]            len_err_o
);

   localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   function automatic int total_beats();
      int s = 0;
      for (int i = 0; i < NCHAN; i++) s += int'(CHAN_BEATS[8*i +: 8]);
      return s;
   endfunction

   localparam int               BTT     = total_beats() * DATA_WIDTH / 8;
   localparam logic [BTT_W-1:0] BTT_V   = BTT_W'(BTT);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCHAN - 1);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [7:0]          beat_q, beat_d;
   logic                pad_q, pad_d;
   logic [NCHAN-1:0]    mask_q, mask_d, len_err_q, len_err_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   logic [7:0]          cur_beats;
   logic [DATA_WIDTH-1:0] cur_data;
   logic                cur_valid, cur_last, last_beat, ch_is_last, zero_src;
   logic                hdr_fire, advance, set_err, tag_push, tag_pop;
   logic                tag_empty, tag_full;
   logic [TAG_W-1:0]    tag_dout;
   logic                unused_bits;

   assign cur_beats  = CHAN_BEATS[8*ch_q +: 8];
   assign cur_data   = s_ch_tdata[DATA_WIDTH*ch_q +: DATA_WIDTH];
   assign cur_valid  = s_ch_tvalid[ch_q];
   assign cur_last   = s_ch_tlast[ch_q];
   assign last_beat  = (beat_q == cur_beats - 8'd1);
   assign ch_is_last = (ch_q == LAST_CH);
   // Masked channels and the tail of a short packet are synthesised as zero beats.
   assign zero_src   = mask_q[ch_q] || pad_q;
   assign hdr_fire   = m_hdr_tvalid && m_hdr_tready;
   assign unused_bits = ^{s_done_tdata[15:13], s_stat_tdata[3:0]};

   always_ff @(posedge memclk) begin
      if (memrst) begin
         state_q   <= ST_IDLE;
         ch_q      <= '0;
         beat_q    <= '0;
         pad_q     <= 1'b0;
         mask_q    <= '0;
         len_err_q <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         beat_q    <= beat_d;
         pad_q     <= pad_d;
         mask_q    <= mask_d;
         len_err_q <= len_err_d;
      end
   end

   always_ff @(posedge memclk) addr_q <= addr_d;

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      beat_d    = beat_q;
      pad_d     = pad_q;
      mask_d    = mask_q;
      len_err_d = len_err_q;
      addr_d    = addr_q;
      advance   = 1'b0;
      set_err   = 1'b0;
      tag_push  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_done_tvalid && (&(s_ch_tvalid | mask_i)) && !tag_full) begin
               state_d = ST_ISSUE;
               mask_d  = mask_i;
               addr_d  = s_done_tdata[ADDR_W-1:0];
            end
         end
         ST_ISSUE: begin
            if (m_cmd_tready) begin
               tag_push = 1'b1;
               state_d  = ST_STREAM;
               ch_d     = '0;
               beat_d   = '0;
               pad_d    = 1'b0;
            end
         end
         ST_STREAM: begin
            if (hdr_fire) begin
               if (last_beat) begin
                  if (!zero_src && !cur_last) begin
                     set_err = 1'b1;
                     state_d = ST_DRAIN;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
                  if (!zero_src && cur_last) begin
                     set_err = 1'b1;
                     pad_d   = 1'b1;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (cur_valid && cur_last) advance = 1'b1;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (set_err) len_err_d[ch_q] = 1'b1;
      if (advance) begin
         if (ch_is_last) begin
            state_d = ST_ACK;
         end else begin
            state_d = ST_STREAM;
            ch_d    = ch_q + CH_W'(1);
            beat_d  = '0;
            pad_d   = 1'b0;
         end
      end
   end

   always_comb begin
      m_cmd_tvalid  = 1'b0;
      m_hdr_tvalid  = 1'b0;
      m_hdr_tdata   = '0;
      m_hdr_tlast   = 1'b0;
      s_ch_tready   = '0;
      s_done_tready = 1'b0;
      case (state_q)
         ST_ISSUE: m_cmd_tvalid = 1'b1;
         ST_STREAM: begin
            m_hdr_tlast = ch_is_last && last_beat;
            if (zero_src) begin
               m_hdr_tvalid = 1'b1;
            end else begin
               m_hdr_tvalid      = cur_valid;
               m_hdr_tdata       = cur_data;
               s_ch_tready[ch_q] = m_hdr_tready;
            end
         end
         ST_DRAIN: s_ch_tready[ch_q] = 1'b1;
         ST_ACK:   s_done_tready = 1'b1;
         default: ;
      endcase
   end

   assign m_cmd_tdata   = make_cmd(addr_q, BASE_ADDR, BTT_V);
   assign len_err_o     = len_err_q;
   assign m_cmpl_tvalid = s_stat_tvalid && !tag_empty;
   assign tag_pop       = m_cmpl_tvalid && m_cmpl_tready;
   assign s_stat_tready = tag_pop;
   assign m_cmpl_tdata  = make_cmpl(tag_dout[ADDR_W-1:0], tag_dout[TAG_W-1], s_stat_tdata[7:4]);

   hdr_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(TAG_W)) u_tag_fifo (
      .clk       (memclk),
      .rst       (memrst),
      .push_i    (tag_push),
      .din_i     ({1'b0, addr_q}),
      .pop_i     (tag_pop),
      .set_err_i (set_err),
      .dout_o    (tag_dout),
      .empty_o   (tag_empty),
      .full_o    (tag_full)
   );

endmodule
